// File: rtl/opfetch_pkg.sv
// Shared widths and the decoded-instruction payload for the operand fetch stage.
package opfetch_pkg;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned SB_DEPTH = 1 << ADDR_W;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rd;
    logic              wen;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
  } issue_t;

  // True when a valid writeback targets the given register address.
  function automatic logic addr_hit(input logic             valid,
                                    input logic [ADDR_W-1:0] a,
                                    input logic [ADDR_W-1:0] b);
    return valid && (a == b);
  endfunction

endpackage

// File: rtl/operand_fetch_pending_scoreboard.sv
// One pending bit per architectural register; set by issue, cleared by writeback.
module pending_scoreboard
  import opfetch_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rs1_pend_c,
  output logic              rs2_pend_c,
  output logic              rd_pend_c
);

  logic [SB_DEPTH-1:0] pend_q;
  logic [SB_DEPTH-1:0] pend_d;

  // Clear first so a same-address set on the same edge wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
    if (set_en_i) pend_d[set_addr_i] = 1'b1;
  end

  // Pending bit storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign rs1_pend_c = pend_q[rs1_addr_i];
  assign rs2_pend_c = pend_q[rs2_addr_i];
  assign rd_pend_c  = pend_q[rd_addr_i];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: hazard check against the pending scoreboard, reg_file read,
// one-entry output register toward execute.
// Optional feature: define BYPASS_EN to forward same-cycle writeback data to sources.
module operand_fetch
  import opfetch_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  output logic [ADDR_W-1:0] r1_addr,
  output logic [ADDR_W-1:0] r2_addr,
  input  logic [DATA_W-1:0] r1_data,
  input  logic [DATA_W-1:0] r2_data,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wen,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [CNT_W-1:0]  stall_count
);

  issue_t            iss_c;
  logic              rs1_pend_c;
  logic              rs2_pend_c;
  logic              rd_pend_c;
  logic              wb_hit1_c;
  logic              wb_hit2_c;
  logic              src1_haz_c;
  logic              src2_haz_c;
  logic              hazard_c;
  logic              accept_c;
  logic [DATA_W-1:0] opa_c;
  logic [DATA_W-1:0] opb_c;

  logic              out_valid_q, out_valid_d;
  logic [OP_W-1:0]   out_op_q,    out_op_d;
  logic [ADDR_W-1:0] out_rd_q,    out_rd_d;
  logic              out_wen_q,   out_wen_d;
  logic [DATA_W-1:0] out_a_q,     out_a_d;
  logic [DATA_W-1:0] out_b_q,     out_b_d;
  logic [CNT_W-1:0]  stall_q,     stall_d;

  assign iss_c   = '{op: in_op, rd: in_rd, wen: in_wen, rs1: in_rs1, rs2: in_rs2};
  assign r1_addr = iss_c.rs1;
  assign r2_addr = iss_c.rs2;

  pending_scoreboard u_sb (
    .clock      (clock),
    .reset      (reset),
    .set_en_i   (accept_c && iss_c.wen),
    .set_addr_i (iss_c.rd),
    .clr_en_i   (wb_valid),
    .clr_addr_i (wb_addr),
    .rs1_addr_i (iss_c.rs1),
    .rs2_addr_i (iss_c.rs2),
    .rd_addr_i  (iss_c.rd),
    .rs1_pend_c (rs1_pend_c),
    .rs2_pend_c (rs2_pend_c),
    .rd_pend_c  (rd_pend_c)
  );

  assign wb_hit1_c = addr_hit(wb_valid, wb_addr, iss_c.rs1);
  assign wb_hit2_c = addr_hit(wb_valid, wb_addr, iss_c.rs2);

`ifdef BYPASS_EN
  // Writeback this cycle resolves the pending source; its data is forwarded.
  assign src1_haz_c = rs1_pend_c && !wb_hit1_c;
  assign src2_haz_c = rs2_pend_c && !wb_hit2_c;
`else
  // reg_file read of a register being written this cycle is stale; wait one cycle.
  assign src1_haz_c = rs1_pend_c || wb_hit1_c;
  assign src2_haz_c = rs2_pend_c || wb_hit2_c;
`endif

  // Without bypass a writeback hit always blocks issue, so the mux never selects wb_data there.
  assign opa_c = wb_hit1_c ? wb_data : r1_data;
  assign opb_c = wb_hit2_c ? wb_data : r2_data;

  assign hazard_c = in_valid && (src1_haz_c || src2_haz_c || (iss_c.wen && rd_pend_c));
  assign in_ready = !hazard_c && (!out_valid_q || out_ready);
  assign accept_c = in_valid && in_ready;

  // Output register load/drain and hazard stall counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_rd_d    = out_rd_q;
    out_wen_d   = out_wen_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    stall_d     = stall_q;
    if (accept_c) begin
      out_valid_d = 1'b1;
      out_op_d    = iss_c.op;
      out_rd_d    = iss_c.rd;
      out_wen_d   = iss_c.wen;
      out_a_d     = opa_c;
      out_b_d     = opb_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (hazard_c && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_rd_q    <= '0;
      out_wen_q   <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      stall_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_rd_q    <= out_rd_d;
      out_wen_q   <= out_wen_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_op      = out_op_q;
  assign out_rd      = out_rd_q;
  assign out_wen     = out_wen_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed hazard scenarios then random traffic,
// checked against an array-based model of registers, pending bits and the output slot.
module tb_operand_fetch;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_op = '0;
  logic [7:0] in_rd = '0;
  logic       in_wen = 1'b0;
  logic [7:0] in_rs1 = '0;
  logic [7:0] in_rs2 = '0;
  logic [7:0] r1_addr, r2_addr;
  logic [7:0] r1_data, r2_data;
  logic       wb_valid = 1'b0;
  logic [7:0] wb_addr = '0;
  logic [7:0] wb_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_op;
  logic [7:0] out_rd;
  logic       out_wen;
  logic [7:0] out_a, out_b;
  logic [15:0] stall_count;

  // Reference state
  logic [7:0] regs [256];
  bit         pend_m [256];
  bit         m_ov;
  logic [3:0] m_op;
  logic [7:0] m_rd;
  bit         m_wen;
  logic [7:0] m_a, m_b;
  int         m_stall;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // The bench plays reg_file: combinational reads of the register array.
  assign r1_data = regs[in_rs1];
  assign r2_data = regs[in_rs2];

  operand_fetch dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_wen(in_wen), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .r1_addr(r1_addr), .r2_addr(r2_addr), .r1_data(r1_data), .r2_data(r2_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd),
    .out_wen(out_wen), .out_a(out_a), .out_b(out_b), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A source is blocked if still pending; writeback in the same cycle changes that per build.
  function automatic bit src_blocked(input logic [7:0] r);
    bit hit;
    hit = wb_valid && (wb_addr == r);
`ifdef BYPASS_EN
    return pend_m[r] && !hit;
`else
    return pend_m[r] || hit;
`endif
  endfunction

  task automatic drive(input bit v, input logic [3:0] op, input logic [7:0] rd, input bit wen,
                       input logic [7:0] rs1, input logic [7:0] rs2, input bit wv,
                       input logic [7:0] wa, input logic [7:0] wd, input bit ordy);
    in_valid = v;  in_op = op;  in_rd = rd;  in_wen = wen;  in_rs1 = rs1;  in_rs2 = rs2;
    wb_valid = wv; wb_addr = wa; wb_data = wd; out_ready = ordy;
  endtask

  // One clock: check handshake before the edge, advance the model, check registers after.
  task automatic step(input string tag);
    bit haz, rdy, acc, wv, ordy, wen;
    logic [7:0] a, b, wa, wd, rd;
    logic [3:0] op;
    #1;
    haz  = in_valid && (src_blocked(in_rs1) || src_blocked(in_rs2) || (in_wen && pend_m[in_rd]));
    rdy  = !haz && (!m_ov || out_ready);
    acc  = in_valid && rdy;
    a    = (wb_valid && wb_addr == in_rs1) ? wb_data : regs[in_rs1];
    b    = (wb_valid && wb_addr == in_rs2) ? wb_data : regs[in_rs2];
    wv = wb_valid; wa = wb_addr; wd = wb_data; ordy = out_ready;
    wen = in_wen; rd = in_rd; op = in_op;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, ".r1_addr"},  32'(r1_addr),  32'(in_rs1));
    @(posedge clock);
    #1;
    if (wv) pend_m[wa] = 1'b0;
    if (acc && wen) pend_m[rd] = 1'b1;
    if (wv) regs[wa] = wd;
    if (acc) begin
      m_ov = 1'b1; m_op = op; m_rd = rd; m_wen = wen; m_a = a; m_b = b;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    if (haz && m_stall != 65535) m_stall++;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk({tag, ".out_op"},  32'(out_op),  32'(m_op));
      chk({tag, ".out_rd"},  32'(out_rd),  32'(m_rd));
      chk({tag, ".out_wen"}, 32'(out_wen), 32'(m_wen));
      chk({tag, ".out_a"},   32'(out_a),   32'(m_a));
      chk({tag, ".out_b"},   32'(out_b),   32'(m_b));
    end
    chk({tag, ".stall"}, 32'(stall_count), 32'(m_stall));
  endtask

  // Asynchronous reset: outputs clear without a clock edge; addresses stay combinational.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 256; i++) pend_m[i] = 1'b0;
    m_ov = 1'b0; m_op = '0; m_rd = '0; m_wen = 1'b0; m_a = '0; m_b = '0; m_stall = 0;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_op"},    32'(out_op),    32'd0);
    chk({tag, ".out_rd"},    32'(out_rd),    32'd0);
    chk({tag, ".out_wen"},   32'(out_wen),   32'd0);
    chk({tag, ".out_a"},     32'(out_a),     32'd0);
    chk({tag, ".out_b"},     32'(out_b),     32'd0);
    chk({tag, ".stall"},     32'(stall_count), 32'd0);
    drive(0, 4'd0, 8'd0, 0, 8'h5A, 8'hC3, 0, 8'd0, 8'd0, 1);
    #1;
    chk({tag, ".r1_comb"},  32'(r1_addr),  32'h5A);
    chk({tag, ".r2_comb"},  32'(r2_addr),  32'hC3);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) regs[i] = 8'(i * 3 + 1);
    #2;
    do_reset("rst");

    // Issue writer of r10, then a reader of r10 stalls until writeback.
    drive(1, 4'd1, 8'd10, 1, 8'd1, 8'd2, 0, 8'd0, 8'd0, 1);    step("t2_issue");
    drive(1, 4'd2, 8'd11, 1, 8'd10, 8'd2, 0, 8'd0, 8'd0, 1);   step("t2_stall0");
    step("t2_stall1");
    step("t2_stall2");
    // Writeback of r10 arrives while the reader waits.
    drive(1, 4'd2, 8'd11, 1, 8'd10, 8'd2, 1, 8'd10, 8'h55, 1); step("t3_wb");
    drive(1, 4'd2, 8'd11, 1, 8'd10, 8'd2, 0, 8'd0, 8'd0, 1);   step("t3_after");
    drive(0, 4'd0, 8'd0, 0, 8'd0, 8'd0, 1, 8'd11, 8'h66, 1);    step("t3_clr11");
    drive(0, 4'd0, 8'd0, 0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);      step("t3_idle");

    // Backpressure: held output stable, no stall counted.
    drive(1, 4'd3, 8'd30, 0, 8'd20, 8'd21, 0, 8'd0, 8'd0, 0);  step("t4_issue");
    drive(1, 4'd4, 8'd31, 0, 8'd22, 8'd23, 0, 8'd0, 8'd0, 0);  step("t4_hold0");
    step("t4_hold1");
    drive(1, 4'd4, 8'd31, 0, 8'd22, 8'd23, 0, 8'd0, 8'd0, 1);  step("t4_release");
    drive(0, 4'd0, 8'd0, 0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);      step("t4_drain");

    // Set beats clear on the same edge for r3.
    drive(1, 4'd5, 8'd3, 1, 8'd4, 8'd5, 1, 8'd3, 8'hAA, 1);    step("t5_setwins");
    drive(0, 4'd0, 8'd0, 0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);      step("t5_idle");
    drive(1, 4'd6, 8'd7, 1, 8'd8, 8'd3, 0, 8'd0, 8'd0, 1);     step("t5_stall0");
    step("t5_stall1");
    drive(1, 4'd6, 8'd7, 1, 8'd8, 8'd3, 1, 8'd3, 8'h33, 1);    step("t5_wb");
    drive(1, 4'd6, 8'd7, 1, 8'd8, 8'd3, 0, 8'd0, 8'd0, 1);     step("t5_after");
    drive(0, 4'd0, 8'd0, 0, 8'd0, 8'd0, 1, 8'd7, 8'h77, 1);     step("t5_clean");

    // Reset with r10 pending and a held output, then r10 reader issues immediately.
    drive(1, 4'd7, 8'd10, 1, 8'd9, 8'd9, 0, 8'd0, 8'd0, 0);    step("t6_fill");
    do_reset("t6_rst");
    drive(1, 4'd8, 8'd12, 0, 8'd10, 8'd10, 0, 8'd0, 8'd0, 1);
    #1;
    chk("t6_noblock", 32'(in_ready), 32'd1);
    step("t6_issue");
    drive(0, 4'd0, 8'd0, 0, 8'd0, 8'd0, 0, 8'd0, 8'd0, 1);      step("t6_idle");

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) < 7), 4'($urandom), 8'($urandom_range(0, 15)),
            1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
            ($urandom_range(0, 2) != 0), 8'($urandom_range(0, 15)), 8'($urandom),
            ($urandom_range(0, 3) != 0));
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
